// File: rtl/spi_regfile_pkg.sv
// Shared opcodes, FSM states and status-byte helper for the SPI register file.
package spi_regfile_pkg;

    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] OP_STATUS = 8'h03;

    localparam logic [2:0] STATUS_RSVD = 3'b000;

    typedef enum logic [2:0] {
        S_OP,
        S_WADDR,
        S_WDATA,
        S_RADDR,
        S_RDATA,
        S_DRAIN
    } state_t;

    function automatic logic [7:0] status_byte(input logic badop, input logic [3:0] version);
        return {badop, STATUS_RSVD, version};
    endfunction

endpackage

// File: rtl/regfile_mem.sv
// NREGS x 8 register storage: one synchronous write port, one combinational read port,
// register 0 exported separately.
module regfile_mem #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata,
    output logic [7:0]    reg0
);

    logic [7:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
    assign reg0  = mem_q[0];

endmodule

// File: rtl/spi_regfile.sv
// Byte-level command processor behind spi_device: addressed register file with write,
// auto-incrementing read and a status query; one reply byte per received byte.
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int unsigned NREGS   = 16,
    parameter logic [3:0]  VERSION = 4'h1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel,
    input  logic       recv__ready,
    output logic       recv__ack,
    input  logic [7:0] cmd,
    output logic       sent__ready,
    input  logic       sent__ack,
    output logic [7:0] reply,
    output logic [7:0] ctrl,
    output logic       badop
);

    localparam int unsigned AW = $clog2(NREGS);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [7:0]    reply_q, reply_d;
    logic          recv_ack_q, recv_ack_d;
    logic          sent_ready_q, sent_ready_d;
    logic          badop_q, badop_d;

    logic          we;
    logic [AW-1:0] raddr;
    logic [AW-1:0] addr;
    logic [7:0]    rdata;

    assign addr = cmd[AW-1:0];

    regfile_mem #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (ptr_q),
        .wdata (cmd),
        .raddr (raddr),
        .rdata (rdata),
        .reg0  (ctrl)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        reply_d      = reply_q;
        recv_ack_d   = recv_ack_q;
        sent_ready_d = sent_ready_q;
        badop_d      = badop_q;
        we           = 1'b0;
        raddr        = ptr_q;

        if (recv_ack_q && !recv__ready) begin
            recv_ack_d = 1'b0;
        end else if (sent_ready_q) begin
            sent_ready_d = !sent__ack;
        end else if (recv__ready && !recv_ack_q) begin
            recv_ack_d = 1'b1;
            // A byte arriving as the frame ends is acked but never executed.
            if (sel) begin
                sent_ready_d = 1'b1;
                unique case (state_q)
                    S_OP: begin
                        reply_d = status_byte(badop_q, VERSION);
                        case (cmd)
                            OP_WRITE:  state_d = S_WADDR;
                            OP_READ:   state_d = S_RADDR;
                            OP_STATUS: begin
                                badop_d = 1'b0;
                                state_d = S_DRAIN;
                            end
                            default: begin
                                badop_d = 1'b1;
                                state_d = S_DRAIN;
                            end
                        endcase
                    end
                    S_WADDR: begin
                        ptr_d   = addr;
                        reply_d = 8'h00;
                        state_d = S_WDATA;
                    end
                    S_WDATA: begin
                        we      = 1'b1;
                        reply_d = cmd;
                        ptr_d   = ptr_q + AW'(1);
                    end
                    S_RADDR: begin
                        raddr   = addr;
                        reply_d = rdata;
                        ptr_d   = addr + AW'(1);
                        state_d = S_RDATA;
                    end
                    S_RDATA: begin
                        reply_d = rdata;
                        ptr_d   = ptr_q + AW'(1);
                    end
                    S_DRAIN: reply_d = 8'h00;
                    default: state_d = S_OP;
                endcase
            end
        end

        if (!sel) begin
            state_d      = S_OP;
            sent_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_OP;
            ptr_q        <= '0;
            reply_q      <= 8'h00;
            recv_ack_q   <= 1'b0;
            sent_ready_q <= 1'b0;
            badop_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            reply_q      <= reply_d;
            recv_ack_q   <= recv_ack_d;
            sent_ready_q <= sent_ready_d;
            badop_q      <= badop_d;
        end
    end

    assign recv__ack   = recv_ack_q;
    assign sent__ready = sent_ready_q;
    assign reply       = reply_q;
    assign badop       = badop_q;

endmodule
